// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch and load/store.
// Data wins conflicts, but a pending fetch waits at most MAX_D_BURST cycles.
module mem_port_arbiter #(
  parameter int MAX_D_BURST = 4,
  parameter int AW          = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          ird_i,
  input  logic [AW-1:0] iaddr_i,
  output logic [31:0]   irdata_o,
  output logic          i_stall_o,
  input  logic          drd_i,
  input  logic          dwr_i,
  input  logic [AW-1:0] daddr_i,
  input  logic [31:0]   dwdata_i,
  input  logic [3:0]    dbe_i,
  output logic [31:0]   drdata_o,
  output logic          d_stall_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_rd_o,
  output logic          mem_wr_o,
  output logic [3:0]    mem_be_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  typedef enum logic [1:0] {RESP_NONE, RESP_I, RESP_D} resp_e;

  localparam logic [3:0] MAX_RUN = 4'(MAX_D_BURST);

  resp_e       resp_sel_q, resp_sel_d;
  logic [3:0]  run_q, run_d;
  logic [31:0] irdata_q;
  logic        d_req, grant_i, grant_d;

  // Grants are forced low in reset so every strobe and stall reads 0.
  always_comb begin
    d_req   = drd_i | dwr_i;
    grant_d = !reset_i && d_req && (!ird_i || (run_q < MAX_RUN));
    grant_i = !reset_i && ird_i && !grant_d;
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_be_o    = 4'b0;
    mem_wdata_o = 32'h0;
    if (grant_i) begin
      mem_rd_o   = 1'b1;
      mem_addr_o = {iaddr_i[AW-1:2], 2'b00};
    end else if (grant_d) begin
      mem_addr_o = daddr_i;
      if (dwr_i) begin
        mem_wr_o    = 1'b1;
        mem_be_o    = dbe_i;
        mem_wdata_o = dwdata_i;
      end else begin
        mem_rd_o = 1'b1;
      end
    end
  end

  always_comb begin
    i_stall_o = !reset_i && ird_i && !grant_i;
    d_stall_o = !reset_i && d_req && !grant_d;
  end

  // A write (even with drd_i also high) produces no read response.
  always_comb begin
    resp_sel_d = RESP_NONE;
    if (grant_i)              resp_sel_d = RESP_I;
    else if (grant_d && !dwr_i) resp_sel_d = RESP_D;
  end

  always_comb begin
    run_d = run_q;
    if (!ird_i || grant_i)                 run_d = 4'd0;
    else if (grant_d && (run_q < MAX_RUN)) run_d = run_q + 4'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_sel_q <= RESP_NONE;
      run_q      <= 4'd0;
      irdata_q   <= 32'h0;
    end else begin
      resp_sel_q <= resp_sel_d;
      run_q      <= run_d;
      if (resp_sel_q == RESP_I) irdata_q <= mem_rdata_i;
    end
  end

  // Held word keeps the fetch output stable while fetch is stalled.
  always_comb begin
    irdata_o = (resp_sel_q == RESP_I) ? mem_rdata_i : irdata_q;
    drdata_o = (resp_sel_q == RESP_D) ? mem_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_D_BURST=4, AW=32).
module tb_mem_port_arbiter;
  localparam int AW = 32;

  logic          clk_i = 1'b0, reset_i;
  logic          ird_i, drd_i, dwr_i;
  logic [AW-1:0] iaddr_i, daddr_i;
  logic [31:0]   dwdata_i, mem_rdata_i;
  logic [3:0]    dbe_i;
  logic [31:0]   irdata_o, drdata_o, mem_wdata_o;
  logic          i_stall_o, d_stall_o, mem_rd_o, mem_wr_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_be_o;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MAX_D_BURST(4), .AW(AW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ird_i(ird_i), .iaddr_i(iaddr_i), .irdata_o(irdata_o), .i_stall_o(i_stall_o),
    .drd_i(drd_i), .dwr_i(dwr_i), .daddr_i(daddr_i), .dwdata_i(dwdata_i), .dbe_i(dbe_i),
    .drdata_o(drdata_o), .d_stall_o(d_stall_o),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ird_i = 0; drd_i = 0; dwr_i = 0;
    iaddr_i = '0; daddr_i = '0; dwdata_i = '0; dbe_i = '0;
  endtask

  task automatic test_reset();
    reset_i = 1; idle(); mem_rdata_i = 32'h1234_5678; ird_i = 1; drd_i = 1;
    #1;
    checks++; if (i_stall_o !== 1'b0) begin errors++; $display("FAIL rst_istall got %b exp 0", i_stall_o); end
    checks++; if (d_stall_o !== 1'b0) begin errors++; $display("FAIL rst_dstall got %b exp 0", d_stall_o); end
    checks++; if (mem_rd_o !== 1'b0) begin errors++; $display("FAIL rst_memrd got %b exp 0", mem_rd_o); end
    checks++; if (irdata_o !== 32'h0) begin errors++; $display("FAIL rst_irdata got %h exp 0", irdata_o); end
    checks++; if (drdata_o !== 32'h0) begin errors++; $display("FAIL rst_drdata got %h exp 0", drdata_o); end
    tick(); tick();
    reset_i = 0; idle();
    tick();
  endtask

  task automatic test_fetch_only();
    ird_i = 1; iaddr_i = 32'h100;
    #1;
    checks++; if (i_stall_o !== 1'b0) begin errors++; $display("FAIL f_istall got %b exp 0", i_stall_o); end
    checks++; if (mem_addr_o !== 32'h100) begin errors++; $display("FAIL f_addr0 got %h exp 100", mem_addr_o); end
    checks++; if (mem_rd_o !== 1'b1) begin errors++; $display("FAIL f_rd got %b exp 1", mem_rd_o); end
    checks++; if (d_stall_o !== 1'b0) begin errors++; $display("FAIL f_dstall got %b exp 0", d_stall_o); end
    tick();
    iaddr_i = 32'h104; mem_rdata_i = 32'h0000_0013;
    #1;
    checks++; if (irdata_o !== 32'h13) begin errors++; $display("FAIL f_irdata got %h exp 13", irdata_o); end
    checks++; if (mem_addr_o !== 32'h104) begin errors++; $display("FAIL f_addr1 got %h exp 104", mem_addr_o); end
    checks++; if (drdata_o !== 32'h0) begin errors++; $display("FAIL f_drdata got %h exp 0", drdata_o); end
    tick();
    idle(); mem_rdata_i = 32'h0000_0013;
    tick();
    mem_rdata_i = 32'hFFFF_FFFF;
    #1;
    checks++; if (irdata_o !== 32'h13) begin errors++; $display("FAIL f_hold got %h exp 13", irdata_o); end
    checks++; if (mem_rd_o !== 1'b0 || mem_addr_o !== 32'h0) begin errors++; $display("FAIL f_idle got rd=%b addr=%h exp rd=0 addr=0", mem_rd_o, mem_addr_o); end
  endtask

  task automatic test_conflict();
    ird_i = 1; iaddr_i = 32'h108; drd_i = 1; daddr_i = 32'h2000;
    for (int c = 0; c < 4; c++) begin
      mem_rdata_i = 32'hBAD0_0000 + 32'(c);
      #1;
      checks++; if (mem_addr_o !== 32'h2000 || mem_rd_o !== 1'b1) begin errors++; $display("FAIL cf_dgrant%0d got addr=%h rd=%b exp addr=2000 rd=1", c, mem_addr_o, mem_rd_o); end
      checks++; if (i_stall_o !== 1'b1 || d_stall_o !== 1'b0) begin errors++; $display("FAIL cf_stall%0d got i=%b d=%b exp i=1 d=0", c, i_stall_o, d_stall_o); end
      checks++; if (irdata_o !== 32'h13) begin errors++; $display("FAIL cf_ihold%0d got %h exp 13", c, irdata_o); end
      if (c > 0) begin
        checks++; if (drdata_o !== 32'hBAD0_0000 + 32'(c)) begin errors++; $display("FAIL cf_drdata%0d got %h exp %h", c, drdata_o, 32'hBAD0_0000 + 32'(c)); end
      end
      tick();
    end
    mem_rdata_i = 32'h0BAD_0004;
    #1;
    checks++; if (mem_addr_o !== 32'h108 || i_stall_o !== 1'b0 || d_stall_o !== 1'b1) begin errors++; $display("FAIL cf_igrant got addr=%h i=%b d=%b exp addr=108 i=0 d=1", mem_addr_o, i_stall_o, d_stall_o); end
    tick();
    mem_rdata_i = 32'h0000_0055;
    #1;
    checks++; if (irdata_o !== 32'h55) begin errors++; $display("FAIL cf_irdata got %h exp 55", irdata_o); end
    checks++; if (mem_addr_o !== 32'h2000 || i_stall_o !== 1'b1) begin errors++; $display("FAIL cf_regrant got addr=%h i=%b exp addr=2000 i=1", mem_addr_o, i_stall_o); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_store();
    dwr_i = 1; daddr_i = 32'h2004; dbe_i = 4'b0011; dwdata_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (mem_wr_o !== 1'b1 || mem_rd_o !== 1'b0) begin errors++; $display("FAIL st_strobe got wr=%b rd=%b exp wr=1 rd=0", mem_wr_o, mem_rd_o); end
    checks++; if (mem_be_o !== 4'b0011) begin errors++; $display("FAIL st_be got %b exp 0011", mem_be_o); end
    checks++; if (mem_wdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_wdata got %h exp deadbeef", mem_wdata_o); end
    checks++; if (mem_addr_o !== 32'h2004 || d_stall_o !== 1'b0) begin errors++; $display("FAIL st_addr got addr=%h d=%b exp addr=2004 d=0", mem_addr_o, d_stall_o); end
    tick();
    idle(); mem_rdata_i = 32'h1111_1111;
    #1;
    checks++; if (drdata_o !== 32'h0) begin errors++; $display("FAIL st_drdata got %h exp 0", drdata_o); end
    checks++; if (mem_wdata_o !== 32'h0 || mem_be_o !== 4'b0) begin errors++; $display("FAIL st_idle got wdata=%h be=%b exp 0", mem_wdata_o, mem_be_o); end
  endtask

  task automatic test_back_to_back();
    drd_i = 1; daddr_i = 32'h3000;
    tick();
    idle(); ird_i = 1; iaddr_i = 32'h200; mem_rdata_i = 32'hAAAA_5555;
    #1;
    checks++; if (drdata_o !== 32'hAAAA_5555) begin errors++; $display("FAIL bb_drdata got %h exp aaaa5555", drdata_o); end
    checks++; if (mem_addr_o !== 32'h200 || mem_rd_o !== 1'b1) begin errors++; $display("FAIL bb_igrant got addr=%h rd=%b exp addr=200 rd=1", mem_addr_o, mem_rd_o); end
    tick();
    idle(); mem_rdata_i = 32'h1234_5678;
    #1;
    checks++; if (irdata_o !== 32'h1234_5678) begin errors++; $display("FAIL bb_irdata got %h exp 12345678", irdata_o); end
    checks++; if (drdata_o !== 32'h0) begin errors++; $display("FAIL bb_dzero got %h exp 0", drdata_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    // Two D grants against a pending fetch leave the burst counter at 2.
    ird_i = 1; iaddr_i = 32'h300; drd_i = 1; daddr_i = 32'h40;
    tick(); tick();
    reset_i = 1; mem_rdata_i = 32'hCAFE_F00D;
    #1;
    checks++; if (drdata_o !== 32'h0 || irdata_o !== 32'h0) begin errors++; $display("FAIL rm_data got d=%h i=%h exp 0", drdata_o, irdata_o); end
    checks++; if (mem_rd_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_wr_o !== 1'b0) begin errors++; $display("FAIL rm_mem got rd=%b wr=%b addr=%h exp 0", mem_rd_o, mem_wr_o, mem_addr_o); end
    checks++; if (i_stall_o !== 1'b0 || d_stall_o !== 1'b0) begin errors++; $display("FAIL rm_stall got i=%b d=%b exp 0", i_stall_o, d_stall_o); end
    tick();
    reset_i = 0; idle(); mem_rdata_i = 32'h9999_9999;
    #1;
    checks++; if (drdata_o !== 32'h0 || irdata_o !== 32'h0) begin errors++; $display("FAIL rm_post got d=%h i=%h exp 0", drdata_o, irdata_o); end
    ird_i = 1; iaddr_i = 32'h300; drd_i = 1; daddr_i = 32'h40;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (i_stall_o !== 1'b1 || mem_addr_o !== 32'h40) begin errors++; $display("FAIL rm_run%0d got i=%b addr=%h exp i=1 addr=40", c, i_stall_o, mem_addr_o); end
      tick();
    end
    #1;
    checks++; if (i_stall_o !== 1'b0 || mem_addr_o !== 32'h300) begin errors++; $display("FAIL rm_igrant got i=%b addr=%h exp i=0 addr=300", i_stall_o, mem_addr_o); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_rdwr_both();
    ird_i = 1; iaddr_i = 32'h400; drd_i = 1; dwr_i = 1;
    daddr_i = 32'h2008; dbe_i = 4'hF; dwdata_i = 32'h5A5A_5A5A;
    #1;
    checks++; if (mem_wr_o !== 1'b1 || mem_rd_o !== 1'b0) begin errors++; $display("FAIL rw_strobe got wr=%b rd=%b exp wr=1 rd=0", mem_wr_o, mem_rd_o); end
    checks++; if (i_stall_o !== 1'b1 || d_stall_o !== 1'b0) begin errors++; $display("FAIL rw_stall got i=%b d=%b exp i=1 d=0", i_stall_o, d_stall_o); end
    checks++; if (mem_addr_o !== 32'h2008 || mem_wdata_o !== 32'h5A5A_5A5A) begin errors++; $display("FAIL rw_addr got addr=%h wdata=%h exp 2008 5a5a5a5a", mem_addr_o, mem_wdata_o); end
    tick();
    idle(); mem_rdata_i = 32'h7777_7777;
    #1;
    checks++; if (drdata_o !== 32'h0) begin errors++; $display("FAIL rw_drdata got %h exp 0", drdata_o); end
    tick();
  endtask

  initial begin
    mem_rdata_i = '0;
    test_reset();
    test_fetch_only();
    test_conflict();
    test_store();
    test_back_to_back();
    test_reset_mid();
    test_rdwr_both();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the core's instruction-fetch port and its load/store port.
- Sits between the pipeline (ird/iaddr, drd/dwr/daddr/dwdata/dbe) and the unified memory macro.
- Issues at most one memory request per cycle, gives data priority with a bounded-starvation guarantee for fetch, stalls the losing requester, and routes the 1-cycle-latency read response back to its owner.

Parameters:
- MAX_D_BURST, 4: max consecutive data grants while a fetch is pending; range 1..15.
- AW, 32: address width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous reset, active-high
- ird_i  in  1  instruction read request
- iaddr_i  in  AW  instruction address
- irdata_o  out  32  instruction word
- i_stall_o  out  1  fetch not granted this cycle
- drd_i  in  1  data read request
- dwr_i  in  1  data write request
- daddr_i  in  AW  data address
- dwdata_i  in  32  write data
- dbe_i  in  4  write byte enables
- drdata_o  out  32  load data
- d_stall_o  out  1  data request not granted this cycle
- mem_addr_o  out  AW  memory address
- mem_rd_o  out  1  memory read strobe
- mem_wr_o  out  1  memory write strobe
- mem_be_o  out  4  memory byte enables
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, valid the cycle after mem_rd_o

Behaviour:
- State:
  - resp_sel_q: NONE, I or D. Owner of the response arriving this cycle.
  - run_q: 4-bit consecutive-data-grant counter.
  - irdata_q: 32-bit held instruction word.
- Request logic is combinational in cycle T:
  - d_req = drd_i | dwr_i.
  - If d_req and ird_i and run_q < MAX_D_BURST: grant D.
  - If d_req and ird_i and run_q >= MAX_D_BURST: grant I.
  - If only one requester: grant it.
  - If none: no grant, and all mem_* strobes are 0.
- Grant I:
  - mem_rd_o=1, mem_addr_o={iaddr_i[AW-1:2],2'b00}, mem_wr_o=0, mem_be_o=0.
- Grant D:
  - mem_addr_o=daddr_i.
  - If dwr_i: mem_wr_o=1, mem_be_o=dbe_i, mem_wdata_o=dwdata_i.
  - Otherwise: mem_rd_o=1.
  - dwr_i and drd_i both high: the write is performed and no read response is produced.
- Stalls:
  - i_stall_o = ird_i & ~grantI.
  - d_stall_o = d_req & ~grantD.
  - No stall asserts without the matching request.
- Idle values: mem_wdata_o=0 and mem_be_o=0 when no write is granted. mem_addr_o=0 when no grant.
- Response, cycle T+1:
  - resp_sel_q <= I on an I grant; D on a D read grant; NONE otherwise (this includes D writes).
  - irdata_o = (resp_sel_q==I) ? mem_rdata_i : irdata_q.
  - irdata_q <= mem_rdata_i when resp_sel_q==I.
  - The instruction word therefore stays stable across fetch stalls.
  - drdata_o = (resp_sel_q==D) ? mem_rdata_i : 32'h0. Load data is zero whenever no read response is present.
- Starvation counter run_q:
  - Increments on a D grant while ird_i=1, saturating at MAX_D_BURST.
  - Clears on an I grant, or on any cycle with ird_i=0.
  - Consequence: a pending fetch waits at most MAX_D_BURST cycles.
- Latency: grant to response is exactly 1 cycle. Back-to-back grants to alternating owners are allowed every cycle.
- Reset (async, any time): resp_sel_q=NONE, run_q=0, irdata_q=0.
  - All outputs are 0 while reset_i=1. This includes both stalls.
  - A response in flight at reset is discarded; the first cycle after release has drdata_o=0 and irdata_o=0.
- Requests are sampled every cycle and are not latched. A stalled requester must hold its request and address.
- The arbiter stores no request state beyond run_q.

Test Plan:
1. Fetch only: ird_i=1, iaddr_i=0x100 (then 0x104); mem_rdata_i returns 0x00000013 -> i_stall_o=0, mem_addr_o=0x100 with mem_rd_o=1, and irdata_o=0x00000013 the next cycle. d_stall_o=0 and drdata_o=0 throughout.
2. Conflict: ird_i=1 with drd_i=1, daddr_i=0x2000, MAX_D_BURST=4 -> D granted for 4 cycles with i_stall_o=1. I granted in the 5th cycle with d_stall_o=1. irdata_o holds its previous value during the stall.
3. Store: dwr_i=1, daddr_i=0x2004, dbe_i=4'b0011, dwdata_i=0xDEADBEEF -> mem_wr_o=1, mem_be_o=0011, mem_wdata_o=0xDEADBEEF, d_stall_o=0. Next cycle drdata_o=0.
4. Load response routing: D read at T, I read at T+1, mem_rdata_i=0xAAAA5555 then 0x12345678 -> drdata_o=0xAAAA5555 at T+1, irdata_o=0x12345678 at T+2, drdata_o=0 at T+2.
5. Reset mid-operation: assert reset_i in the cycle after a D read grant -> all outputs 0 immediately. After release, drdata_o=0, irdata_o=0, run_q restarts at 0.
6. drd_i=dwr_i=1 and ird_i=1 with run_q=0 -> write granted, mem_rd_o=0, i_stall_o=1, and no load data the next cycle.
